// File: rtl/usb_buf_pkg.sv
// Shared types and constants for the endpoint buffer arbitration slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// arb_state_t  : buffer ownership state (IDLE or one of the three grants)
// BUF_DEPTH_DEF: default endpoint buffer capacity in bytes
// OCC_W        : occupancy width, wide enough to represent 0..BUF_DEPTH_DEF
package usb_buf_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_RX   = 2'd1,
        GNT_TX   = 2'd2,
        GNT_HOST = 2'd3
    } arb_state_t;

    localparam int BUF_DEPTH_DEF = 64;
    localparam int OCC_W         = 7;

endpackage

// File: rtl/grant_timer.sv
// Saturating inactivity timer for the current buffer owner.
// Latency: expire is registered-count compare, valid the cycle the count reaches LIMIT.
// Backpressure: none; clr has priority over en, count holds at all-ones.
//
// clk, n_rst : clock, async active-low reset
// clr        : zero the count (no owner, or owner strobed this cycle)
// en         : count this cycle (buffer is granted)
// expire     : count has reached LIMIT
module grant_timer #(
    parameter int TMR_W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            // Saturate rather than wrap so a stuck owner can never alias back to zero.
            count <= count + TMR_W'(1);
        end
    end

    assign expire = (count == TMR_W'(LIMIT));

endmodule

// File: rtl/buffer_arbiter.sv
// Packet-level arbiter sharing the endpoint buffer between USB RX, USB TX and the AHB host.
// Latency: grants/busy one cycle after request; buffer strobes and error pulses are zero-latency.
// Backpressure: none toward requesters; full/empty strobes are dropped and flagged instead.
//
// clk, n_rst                      : clock, async active-low reset
// rx_req/strobe/byte/done/error   : USB RX packet engine (writer)
// tx_req/strobe/done              : USB TX packet engine (reader)
// host_req/wr_strobe/wr_byte/
//   rd_strobe/done/clear          : AHB host slave (reader/writer, buffer clear)
// buffer_occupancy                : current fill level from data_buffer, 0..BUF_DEPTH
// rx_gnt, tx_gnt, host_gnt, busy  : registered ownership outputs
// buf_store/data/get/flush/clear  : strobes to data_buffer
// overflow_err, underflow_err,
//   timeout_err                   : single-cycle error pulses
module buffer_arbiter
    import usb_buf_pkg::*;
#(
    parameter int BUF_DEPTH      = BUF_DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMR_W          = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rx_req,
    input  logic             rx_strobe,
    input  logic [7:0]       rx_byte,
    input  logic             rx_done,
    input  logic             rx_error,
    input  logic             tx_req,
    input  logic             tx_strobe,
    input  logic             tx_done,
    input  logic             host_req,
    input  logic             host_wr_strobe,
    input  logic [7:0]       host_wr_byte,
    input  logic             host_rd_strobe,
    input  logic             host_done,
    input  logic             host_clear,
    input  logic [OCC_W-1:0] buffer_occupancy,
    output logic             rx_gnt,
    output logic             tx_gnt,
    output logic             host_gnt,
    output logic             buf_store,
    output logic [7:0]       buf_data,
    output logic             buf_get,
    output logic             buf_flush,
    output logic             buf_clear,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             timeout_err,
    output logic             busy
);

    arb_state_t state;
    logic       last_usb;      // last grant went to a USB engine; host gets the next turn
    logic       granted;
    logic       owner_strobe;
    logic       owner_release;
    logic       timer_expire;
    logic       timeout_hit;
    logic       occ_full;
    logic       occ_empty;

    assign granted     = (state != IDLE);
    assign occ_full    = (buffer_occupancy >= OCC_W'(BUF_DEPTH));
    assign occ_empty   = (buffer_occupancy == '0);
    assign timeout_hit = granted && timer_expire;

    // Any strobe from the owner counts as activity, even one that gets blocked.
    always_comb begin
        owner_strobe  = 1'b0;
        owner_release = 1'b0;
        case (state)
            GNT_RX: begin
                owner_strobe  = rx_strobe;
                owner_release = rx_done || !rx_req || rx_error || timeout_hit;
            end
            GNT_TX: begin
                owner_strobe  = tx_strobe;
                owner_release = tx_done || !tx_req || timeout_hit;
            end
            GNT_HOST: begin
                owner_strobe  = host_wr_strobe || host_rd_strobe;
                owner_release = host_done || !host_req || timeout_hit;
            end
            default: begin
                owner_strobe  = 1'b0;
                owner_release = 1'b0;
            end
        endcase
    end

    grant_timer #(
        .TMR_W (TMR_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_grant_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (!granted || owner_strobe),
        .en     (granted),
        .expire (timer_expire)
    );

    // Ownership FSM. Grants and busy are registered alongside the state so they
    // always agree with it; every release passes through IDLE for one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            last_usb <= 1'b0;
            rx_gnt   <= 1'b0;
            tx_gnt   <= 1'b0;
            host_gnt <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (last_usb && host_req) begin
                        state    <= GNT_HOST;
                        last_usb <= 1'b0;
                        host_gnt <= 1'b1;
                        busy     <= 1'b1;
                    end else if (rx_req) begin
                        state    <= GNT_RX;
                        last_usb <= 1'b1;
                        rx_gnt   <= 1'b1;
                        busy     <= 1'b1;
                    end else if (tx_req) begin
                        state    <= GNT_TX;
                        last_usb <= 1'b1;
                        tx_gnt   <= 1'b1;
                        busy     <= 1'b1;
                    end else if (host_req) begin
                        state    <= GNT_HOST;
                        last_usb <= 1'b0;
                        host_gnt <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    if (owner_release) begin
                        state    <= IDLE;
                        rx_gnt   <= 1'b0;
                        tx_gnt   <= 1'b0;
                        host_gnt <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Strobe mux and guards. A flush or clear wins over any store/get in the
    // same cycle, and a blocked strobe raises its error instead of reaching
    // the buffer (a store at full would make data_buffer self-reset).
    always_comb begin
        buf_store     = 1'b0;
        buf_data      = 8'h00;
        buf_get       = 1'b0;
        buf_flush     = 1'b0;
        buf_clear     = 1'b0;
        overflow_err  = 1'b0;
        underflow_err = 1'b0;
        timeout_err   = timeout_hit;
        case (state)
            IDLE: begin
                buf_clear = host_clear;
            end
            GNT_RX: begin
                if (rx_error || timeout_hit) begin
                    buf_flush = 1'b1;
                end else if (rx_strobe) begin
                    if (occ_full) begin
                        overflow_err = 1'b1;
                    end else begin
                        buf_store = 1'b1;
                        buf_data  = rx_byte;
                    end
                end
            end
            GNT_TX: begin
                if (tx_strobe) begin
                    if (occ_empty) begin
                        underflow_err = 1'b1;
                    end else begin
                        buf_get = 1'b1;
                    end
                end
            end
            GNT_HOST: begin
                if (host_clear) begin
                    buf_clear = 1'b1;
                end else if (host_wr_strobe) begin
                    // Write takes the cycle; a simultaneous read is dropped.
                    if (occ_full) begin
                        overflow_err = 1'b1;
                    end else begin
                        buf_store = 1'b1;
                        buf_data  = host_wr_byte;
                    end
                end else if (host_rd_strobe) begin
                    if (occ_empty) begin
                        underflow_err = 1'b1;
                    end else begin
                        buf_get = 1'b1;
                    end
                end
            end
            default: begin
                buf_store = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed and randomized checks of buffer_arbiter against an ownership-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_buffer_arbiter;

    localparam int DEPTH = 64;
    localparam int TMO   = 255;

    localparam int OWN_NONE = 0;
    localparam int OWN_RX   = 1;
    localparam int OWN_TX   = 2;
    localparam int OWN_HOST = 3;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rx_req, rx_strobe, rx_done, rx_error;
    logic [7:0] rx_byte;
    logic       tx_req, tx_strobe, tx_done;
    logic       host_req, host_wr_strobe, host_rd_strobe, host_done, host_clear;
    logic [7:0] host_wr_byte;
    logic [6:0] buffer_occupancy;
    logic       rx_gnt, tx_gnt, host_gnt;
    logic       buf_store, buf_get, buf_flush, buf_clear;
    logic [7:0] buf_data;
    logic       overflow_err, underflow_err, timeout_err, busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the buffer, whether host has the next turn,
    // and how many granted cycles have passed since the owner last strobed.
    int m_owner;
    bit m_last_usb;
    int m_idle;

    always #5 clk = ~clk;

    buffer_arbiter dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .rx_req           (rx_req),
        .rx_strobe        (rx_strobe),
        .rx_byte          (rx_byte),
        .rx_done          (rx_done),
        .rx_error         (rx_error),
        .tx_req           (tx_req),
        .tx_strobe        (tx_strobe),
        .tx_done          (tx_done),
        .host_req         (host_req),
        .host_wr_strobe   (host_wr_strobe),
        .host_wr_byte     (host_wr_byte),
        .host_rd_strobe   (host_rd_strobe),
        .host_done        (host_done),
        .host_clear       (host_clear),
        .buffer_occupancy (buffer_occupancy),
        .rx_gnt           (rx_gnt),
        .tx_gnt           (tx_gnt),
        .host_gnt         (host_gnt),
        .buf_store        (buf_store),
        .buf_data         (buf_data),
        .buf_get          (buf_get),
        .buf_flush        (buf_flush),
        .buf_clear        (buf_clear),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    task automatic expect_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner    = OWN_NONE;
        m_last_usb = 1'b0;
        m_idle     = 0;
    endtask

    // Compare every output against what the model says this cycle should produce.
    task automatic model_check();
        logic       e_store, e_get, e_flush, e_clear, e_ovf, e_udf, e_to;
        logic [7:0] e_data;
        bit         full, empty, expired;
        e_store = 0; e_get = 0; e_flush = 0; e_clear = 0;
        e_ovf = 0; e_udf = 0; e_to = 0; e_data = 8'h00;
        full    = (int'(buffer_occupancy) >= DEPTH);
        empty   = (buffer_occupancy == 7'd0);
        expired = (m_owner != OWN_NONE) && (m_idle == TMO);
        if (m_owner == OWN_NONE) begin
            if (host_clear) e_clear = 1;
        end else if (m_owner == OWN_RX) begin
            if (rx_error || expired) e_flush = 1;
            else if (rx_strobe) begin
                if (full) e_ovf = 1;
                else begin e_store = 1; e_data = rx_byte; end
            end
        end else if (m_owner == OWN_TX) begin
            if (tx_strobe) begin
                if (empty) e_udf = 1; else e_get = 1;
            end
        end else begin
            if (host_clear) e_clear = 1;
            else if (host_wr_strobe) begin
                if (full) e_ovf = 1;
                else begin e_store = 1; e_data = host_wr_byte; end
            end else if (host_rd_strobe) begin
                if (empty) e_udf = 1; else e_get = 1;
            end
        end
        e_to = expired;
        expect_eq("m_rx_gnt",   rx_gnt,        (m_owner == OWN_RX));
        expect_eq("m_tx_gnt",   tx_gnt,        (m_owner == OWN_TX));
        expect_eq("m_host_gnt", host_gnt,      (m_owner == OWN_HOST));
        expect_eq("m_busy",     busy,          (m_owner != OWN_NONE));
        expect_eq("m_store",    buf_store,     e_store);
        expect_eq("m_data",     buf_data,      e_data);
        expect_eq("m_get",      buf_get,       e_get);
        expect_eq("m_flush",    buf_flush,     e_flush);
        expect_eq("m_clear",    buf_clear,     e_clear);
        expect_eq("m_ovf",      overflow_err,  e_ovf);
        expect_eq("m_udf",      underflow_err, e_udf);
        expect_eq("m_tmo",      timeout_err,   e_to);
    endtask

    task automatic model_update();
        bit strobe, done, req, release_now;
        if (m_owner == OWN_NONE) begin
            m_idle = 0;
            if (m_last_usb && host_req) begin m_owner = OWN_HOST; m_last_usb = 0; end
            else if (rx_req)            begin m_owner = OWN_RX;   m_last_usb = 1; end
            else if (tx_req)            begin m_owner = OWN_TX;   m_last_usb = 1; end
            else if (host_req)          begin m_owner = OWN_HOST; m_last_usb = 0; end
        end else begin
            strobe = 0; done = 0; req = 0;
            if (m_owner == OWN_RX) begin
                strobe = rx_strobe; done = rx_done || rx_error; req = rx_req;
            end else if (m_owner == OWN_TX) begin
                strobe = tx_strobe; done = tx_done; req = tx_req;
            end else begin
                strobe = host_wr_strobe || host_rd_strobe; done = host_done; req = host_req;
            end
            release_now = done || !req || (m_idle == TMO);
            if (release_now) begin
                m_owner = OWN_NONE;
                m_idle  = 0;
            end else if (strobe) begin
                m_idle = 0;
            end else if (m_idle < TMO) begin
                m_idle = m_idle + 1;
            end
        end
    endtask

    task automatic chk();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!n_rst) model_reset();
        else model_update();
        #1;
    endtask

    task automatic cyc();
        chk();
        adv();
    endtask

    initial begin
        logic [7:0] bytes [3];
        int r;
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3;

        n_rst = 0;
        rx_req = 0; rx_strobe = 0; rx_byte = 0; rx_done = 0; rx_error = 0;
        tx_req = 0; tx_strobe = 0; tx_done = 0;
        host_req = 0; host_wr_strobe = 0; host_wr_byte = 0; host_rd_strobe = 0;
        host_done = 0; host_clear = 0;
        buffer_occupancy = 7'd5;
        model_reset();

        // Reset state
        cyc();
        chk();
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_host_gnt", host_gnt, 1'b0);
        expect_eq("rst_store", buf_store, 1'b0);
        adv();
        n_rst = 1;

        // RX and TX request together: RX wins, three bytes, release, gap, then TX
        rx_req = 1; tx_req = 1;
        cyc();
        chk();
        expect_eq("t1_rx_gnt", rx_gnt, 1'b1);
        expect_eq("t1_tx_gnt", tx_gnt, 1'b0);
        adv();
        for (int i = 0; i < 3; i++) begin
            rx_strobe = 1; rx_byte = bytes[i];
            chk();
            expect_eq("t1_store", buf_store, 1'b1);
            expect_eq("t1_data", buf_data, bytes[i]);
            adv();
        end
        rx_strobe = 0; rx_done = 1; rx_req = 0;
        cyc();
        rx_done = 0;
        chk();
        expect_eq("t1_gap_busy", busy, 1'b0);
        adv();
        chk();
        expect_eq("t1_tx_gnt_after", tx_gnt, 1'b1);
        adv();

        // Fairness: host held during RX, TX asks after rx_done, host goes first
        tx_done = 1; tx_req = 0;
        cyc();
        tx_done = 0; rx_req = 1;
        cyc();
        host_req = 1;
        cyc();
        rx_done = 1; rx_req = 0; tx_req = 1;
        cyc();
        rx_done = 0;
        chk();
        expect_eq("t2_gap_busy", busy, 1'b0);
        adv();
        chk();
        expect_eq("t2_host_first", host_gnt, 1'b1);
        expect_eq("t2_tx_waits", tx_gnt, 1'b0);
        adv();
        host_wr_strobe = 1; host_wr_byte = 8'h5C;
        chk();
        expect_eq("t2_wr_store", buf_store, 1'b1);
        expect_eq("t2_wr_data", buf_data, 8'h5C);
        adv();
        host_wr_strobe = 0; host_rd_strobe = 1;
        chk();
        expect_eq("t2_rd_get", buf_get, 1'b1);
        expect_eq("t2_rd_nostore", buf_store, 1'b0);
        adv();
        host_rd_strobe = 0; host_done = 1; host_req = 0;
        cyc();
        host_done = 0;
        cyc();
        chk();
        expect_eq("t2_tx_after_host", tx_gnt, 1'b1);
        adv();

        // Underflow guard in TX
        buffer_occupancy = 7'd0; tx_strobe = 1;
        chk();
        expect_eq("t3_udf_get", buf_get, 1'b0);
        expect_eq("t3_udf_err", underflow_err, 1'b1);
        adv();
        tx_strobe = 0;
        chk();
        expect_eq("t3_udf_single", underflow_err, 1'b0);
        adv();
        buffer_occupancy = 7'd5; tx_req = 0;
        cyc();
        rx_req = 1;
        cyc();

        // Overflow guard in RX
        buffer_occupancy = 7'd64; rx_strobe = 1; rx_byte = 8'h77;
        chk();
        expect_eq("t3_ovf_store", buf_store, 1'b0);
        expect_eq("t3_ovf_err", overflow_err, 1'b1);
        expect_eq("t3_ovf_data", buf_data, 8'h00);
        adv();
        rx_strobe = 0;
        chk();
        expect_eq("t3_ovf_single", overflow_err, 1'b0);
        adv();

        // RX error mid-packet
        buffer_occupancy = 7'd10; rx_strobe = 1; rx_byte = 8'h33; rx_error = 1;
        chk();
        expect_eq("t4_flush", buf_flush, 1'b1);
        expect_eq("t4_nostore", buf_store, 1'b0);
        adv();
        rx_strobe = 0; rx_error = 0; rx_req = 0;
        chk();
        expect_eq("t4_rx_released", rx_gnt, 1'b0);
        adv();

        // Host timeout
        host_req = 1;
        cyc();
        for (int i = 0; i < TMO; i++) cyc();
        chk();
        expect_eq("t5_host_tmo", timeout_err, 1'b1);
        expect_eq("t5_host_noflush", buf_flush, 1'b0);
        host_req = 0;
        adv();
        chk();
        expect_eq("t5_host_dropped", host_gnt, 1'b0);
        adv();

        // RX timeout also flushes
        rx_req = 1;
        cyc();
        for (int i = 0; i < TMO; i++) cyc();
        chk();
        expect_eq("t5_rx_tmo", timeout_err, 1'b1);
        expect_eq("t5_rx_flush", buf_flush, 1'b1);
        rx_req = 0;
        adv();
        chk();
        expect_eq("t5_rx_dropped", rx_gnt, 1'b0);
        adv();

        // Async reset mid-TX with a strobe active
        tx_req = 1;
        cyc();
        tx_strobe = 1;
        chk();
        expect_eq("t6_pre_get", buf_get, 1'b1);
        adv();
        n_rst = 0;
        #1;
        expect_eq("t6_rst_tx_gnt", tx_gnt, 1'b0);
        expect_eq("t6_rst_busy", busy, 1'b0);
        expect_eq("t6_rst_get", buf_get, 1'b0);
        expect_eq("t6_rst_udf", underflow_err, 1'b0);
        model_reset();
        tx_strobe = 0;
        cyc();
        rx_req = 1; tx_req = 1; host_req = 1; n_rst = 1;
        cyc();
        chk();
        expect_eq("t6_post_rx_gnt", rx_gnt, 1'b1);
        expect_eq("t6_post_host_gnt", host_gnt, 1'b0);
        adv();
        rx_req = 0; tx_req = 0; host_req = 0;
        cyc();

        // host_clear honoured in IDLE
        host_clear = 1;
        chk();
        expect_eq("t7_idle_clear", buf_clear, 1'b1);
        adv();
        host_clear = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rx_req         = ($urandom_range(0, 9) < 7);
            tx_req         = ($urandom_range(0, 9) < 6);
            host_req       = ($urandom_range(0, 9) < 5);
            rx_strobe      = $urandom_range(0, 1);
            tx_strobe      = $urandom_range(0, 1);
            host_wr_strobe = $urandom_range(0, 1);
            host_rd_strobe = $urandom_range(0, 1);
            rx_done        = ($urandom_range(0, 7) == 0);
            tx_done        = ($urandom_range(0, 7) == 0);
            host_done      = ($urandom_range(0, 7) == 0);
            rx_error       = ($urandom_range(0, 29) == 0);
            host_clear     = ($urandom_range(0, 19) == 0);
            rx_byte        = 8'($urandom);
            host_wr_byte   = 8'($urandom);
            r = $urandom_range(0, 3);
            if (r == 0)      buffer_occupancy = 7'd0;
            else if (r == 1) buffer_occupancy = 7'd64;
            else             buffer_occupancy = 7'($urandom_range(1, 63));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
